uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- UART receiver; the receive-side counterpart of the team's UART TX path (serializer/FSM/parity/mux).
- Oversamples serial RX_IN at PRESCALE clocks per bit, recovers start, data (LSB first), optional parity and stop bits.
- Presents WIDTH-bit parallel word with a one-cycle valid pulse, plus parity/stop error flags, to the system controller.

Parameters:
WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of PRESCALE input

Ports:
CLK  input  1  system clock
RST  input  1  reset, synchronous, active-low
RX_IN  input  1  serial line; idle high; already synchronized to CLK upstream
PRESCALE  input  PRESCALE_WIDTH  oversampling ratio; legal 8, 16, 32; any other value decoded as 8
PAR_ENABLE  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  WIDTH  last correctly received word
DATA_VALID  output  1  one-cycle pulse: P_DATA updated with a good frame
PAR_ERR  output  1  one-cycle pulse: parity mismatch
STP_ERR  output  1  one-cycle pulse: stop bit sampled 0

Behaviour:
- Reset (RST=0 at posedge): FSM to IDLE, counters cleared, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0; applies mid-frame, and the partial frame is discarded.
- Config latch: PRESCALE, PAR_ENABLE and PAR_TYP are captured on start detection; changes mid-frame are ignored until the next frame.
- Bit timing: edge_cnt runs 0..PRESCALE-1 per bit period. It is set to 0 on the cycle RX_IN is first seen low in IDLE and wraps to 0 while advancing bit_cnt.
- Sample point: majority of the samples at edge_cnt = P/2-1, P/2, P/2+1, with P = latched PRESCALE. The bit value is registered the cycle after the last sample.
- States:
  - IDLE: RX_IN=0 -> START.
  - START: sampled bit 1 (glitch) -> IDLE with no output pulses; else at end of bit -> DATA.
  - DATA: shift WIDTH bits LSB first into a shift register. After bit WIDTH-1 ends -> PARITY if enabled, else STOP.
  - PARITY: compare the sampled bit with the computed parity of the shift register (even: XOR of data; odd: its inverse). Store the mismatch; at end of bit -> STOP.
  - STOP: on the decision cycle (one clock after the final stop sample), return to IDLE without waiting for the end of the stop bit, so back-to-back frames are received.
- Decision cycle outputs:
  - good frame (stop=1, no parity mismatch): P_DATA <= shift register, DATA_VALID=1.
  - stop=0: STP_ERR=1.
  - parity mismatch: PAR_ERR=1.
  - both errors may assert together. On any error DATA_VALID stays 0 and P_DATA is held.
- All pulses are exactly one cycle. P_DATA holds until the next good frame.
- Latency, PRESCALE=8, no parity, majority on, start detect at cycle 0: stop samples at cycles 75..77, DATA_VALID at cycle 78.
- RX_IN low in IDLE immediately after a frame starts the next frame, even on the decision cycle's next clock.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: 3-sample majority vote as described above; the decision for each bit lands at edge_cnt P/2+2.
- Undefined: single sample at edge_cnt P/2; the decision lands at P/2+1. All pulse timings in Behaviour and Test Plan shift one cycle earlier, e.g. DATA_VALID at cycle 77 in the latency example.

Test Plan:
- PRESCALE=8, PAR_ENABLE=1, PAR_TYP=0, send 0xA5 with parity 0, stop 1 -> DATA_VALID pulse at cycle 86 (majority on), P_DATA=0xA5, no error flags.
- PRESCALE=8, RX_IN low 2 cycles then high -> start rejected, FSM back in IDLE, no pulses; a following valid 0x3C frame is received correctly.
- PRESCALE=16, PAR_ENABLE=1, PAR_TYP=1, send 0x3C with parity bit 0 -> PAR_ERR single pulse, DATA_VALID=0, P_DATA keeps its previous value.
- PRESCALE=32, PAR_ENABLE=0, send 0x81 with stop bit 0 -> STP_ERR pulse, no DATA_VALID.
- PRESCALE=16, PAR_ENABLE=0, frames 0x55 then 0xFF back-to-back with no idle gap -> two DATA_VALID pulses 160 cycles apart, with P_DATA=0x55 then 0xFF.
- Mid-frame RST=0 for 1 cycle during DATA, then a full frame 0x0F -> all outputs 0 after reset, partial frame dropped, 0x0F received cleanly.

Source files
------------

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//
// UART receiver. It oversamples RX_IN at PRESCALE clocks per bit and recovers
// the start bit, WIDTH data bits (LSB first), an optional parity bit and the
// stop bit. A good word is presented on P_DATA with a one-cycle DATA_VALID
// pulse. Parity and stop errors are reported as one-cycle pulses.
//
// Build option:
//   UART_RX_MAJORITY_EN  defined   -> 3-sample majority vote around mid-bit,
//                                     decision at edge_cnt P/2+2
//                        undefined -> single sample at edge_cnt P/2,
//                                     decision at edge_cnt P/2+1
//
// Ports:
//   CLK         in   system clock
//   RST         in   synchronous reset, active-low
//   RX_IN       in   serial line, idle high, already synchronized to CLK
//   PRESCALE    in   oversampling ratio (8, 16 or 32; other values act as 8)
//   PAR_ENABLE  in   1 = parity bit present
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   P_DATA      out  last correctly received word
//   DATA_VALID  out  one-cycle pulse, P_DATA updated with a good frame
//   PAR_ERR     out  one-cycle pulse, parity mismatch
//   STP_ERR     out  one-cycle pulse, stop bit sampled 0
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_ENABLE,
  input  logic                      PAR_TYP,
  output logic [WIDTH-1:0]          P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  localparam int PW  = PRESCALE_WIDTH;
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PW-1:0]  PS8       = PW'(8);
  localparam logic [PW-1:0]  PS16      = PW'(16);
  localparam logic [PW-1:0]  PS32      = PW'(32);
  localparam logic [BCW-1:0] LAST_DBIT = BCW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_prescale;
  logic [PW-1:0]    r_edge_cnt;
  logic [BCW-1:0]   r_bit_cnt;
  logic             r_par_en;
  logic             r_par_typ;
  logic             r_par_mis;
  logic             r_bit;
  logic [WIDTH-1:0] r_shift;

  logic [PW-1:0]    w_half;
  logic [PW-1:0]    w_dec_edge;
  logic [PW-1:0]    w_last_edge;
  logic             w_dec_pt;
  logic             w_end_bit;
  logic             w_par_exp;

  // Unsupported ratios fall back to 8 so the bit timer always has a sane period.
  function automatic logic [PW-1:0] decode_prescale(input logic [PW-1:0] p);
    logic [PW-1:0] res;
    if (p == PS16 || p == PS32) res = p;
    else                        res = PS8;
    return res;
  endfunction

  assign w_half      = r_prescale >> 1;
  assign w_last_edge = r_prescale - PW'(1);
  assign w_dec_pt    = (r_edge_cnt == w_dec_edge);
  assign w_end_bit   = (r_edge_cnt == w_last_edge);
  // Even parity bit equals XOR of the data; odd parity is its inverse.
  assign w_par_exp   = (^r_shift) ^ r_par_typ;

`ifdef UART_RX_MAJORITY_EN
  logic r_s0;
  logic r_s1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign w_dec_edge = w_half + PW'(2);

  // Two early samples are held; the third is taken live and the vote is
  // registered, so the FSM acts on it one clock later.
  always_ff @(posedge CLK) begin
    if (r_edge_cnt == w_half - PW'(1)) r_s0  <= RX_IN;
    if (r_edge_cnt == w_half)          r_s1  <= RX_IN;
    if (r_edge_cnt == w_half + PW'(1)) r_bit <= majority3(r_s0, r_s1, RX_IN);
  end
`else
  assign w_dec_edge = w_half + PW'(1);

  always_ff @(posedge CLK) begin
    if (r_edge_cnt == w_half) r_bit <= RX_IN;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_prescale <= PS8;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_mis  <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;

      if (r_state == S_IDLE) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= '0;
        if (!RX_IN) begin
          // The detect cycle is edge 0 of the start bit, so the next clock is edge 1.
          r_state    <= S_START;
          r_edge_cnt <= PW'(1);
          r_prescale <= decode_prescale(PRESCALE);
          r_par_en   <= PAR_ENABLE;
          r_par_typ  <= PAR_TYP;
          r_par_mis  <= 1'b0;
        end
      end else begin
        r_edge_cnt <= w_end_bit ? '0 : r_edge_cnt + PW'(1);

        case (r_state)
          S_START: begin
            if (w_dec_pt && r_bit) begin
              // Line went back high: a glitch, not a start bit.
              r_state    <= S_IDLE;
              r_edge_cnt <= '0;
            end else if (w_end_bit) begin
              r_state <= S_DATA;
            end
          end

          S_DATA: begin
            if (w_dec_pt) r_shift <= {r_bit, r_shift[WIDTH-1:1]};
            if (w_end_bit) begin
              if (r_bit_cnt == LAST_DBIT) begin
                r_bit_cnt <= '0;
                r_state   <= r_par_en ? S_PARITY : S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
              end
            end
          end

          S_PARITY: begin
            if (w_dec_pt)  r_par_mis <= (r_bit != w_par_exp);
            if (w_end_bit) r_state   <= S_STOP;
          end

          S_STOP: begin
            // Leave on the decision cycle, not at end of bit, so a start bit
            // directly following the stop bit is caught.
            if (w_dec_pt) begin
              r_state    <= S_IDLE;
              r_edge_cnt <= '0;
              STP_ERR    <= ~r_bit;
              PAR_ERR    <= r_par_mis;
              if (r_bit && !r_par_mis) begin
                P_DATA     <= r_shift;
                DATA_VALID <= 1'b1;
              end
            end
          end

          default: begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
//
// Directed bench for uart_rx_core. Frames are driven bit by bit on negedges;
// a negedge monitor logs every output pulse with its clock index so pulse
// counts, latencies and captured words can be compared against hand values.
// Latencies are relative to the start-detect clock (t0). Building with
// UART_RX_MAJORITY_EN moves every decision one clock later.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

`ifdef UART_RX_MAJORITY_EN
  localparam int ADJ = 0;
`else
  localparam int ADJ = -1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_core #(
    .WIDTH         (8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_IN     (rx),
    .PRESCALE  (prescale),
    .PAR_ENABLE(par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
    .PAR_ERR   (par_err),
    .STP_ERR   (stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_vec = 0;
  int         n_err = 0;
  int         t0    = 0;
  int         dv_n  = 0;
  int         pe_n  = 0;
  int         se_n  = 0;
  int         dv_cyc [16];
  logic [7:0] dv_dat [16];
  int         pe_cyc = 0;
  int         se_cyc = 0;
  int         b_dv, b_pe, b_se;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cyc[dv_n % 16] = cyc;
      dv_dat[dv_n % 16] = p_data;
      dv_n = dv_n + 1;
    end
    if (par_err) begin
      pe_cyc = cyc;
      pe_n   = pe_n + 1;
    end
    if (stp_err) begin
      se_cyc = cyc;
      se_n   = se_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_dv = dv_n;
    b_pe = pe_n;
    b_se = se_n;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge after the last stop clock.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic pt, input logic pbit, input logic sbit,
                            input logic scramble);
    prescale = p[5:0];
    par_en   = pe;
    par_typ  = pt;
    rx       = 1'b0;
    t0       = cyc + 1;
    repeat (p) @(negedge clk);
    if (scramble) begin
      prescale = 6'd16;
      par_en   = ~pe;
      par_typ  = ~pt;
    end
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (p) @(negedge clk);
    end
    if (pe) begin
      rx = pbit;
      repeat (p) @(negedge clk);
    end
    rx = sbit;
    repeat (p) @(negedge clk);
  endtask

  int t0a;

  initial begin
    rst      = 1'b0;
    rx       = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pdata", p_data, 8'h00);
    check("rst_dv", data_valid, 1'b0);
    check("rst_pe", par_err, 1'b0);
    check("rst_se", stp_err, 1'b0);
    rst = 1'b1;
    idle(5);

    // P=8, even parity, 0xA5 parity 0; config scrambled mid-frame
    snap();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(32);
    check("t1_dv_cnt", dv_n - b_dv, 1);
    check("t1_dv_lat", dv_cyc[b_dv % 16] - t0, 86 + ADJ);
    check("t1_data", dv_dat[b_dv % 16], 8'hA5);
    check("t1_pe_cnt", pe_n - b_pe, 0);
    check("t1_se_cnt", se_n - b_se, 0);

    // start glitch of 2 clocks, then 0x3C
    snap();
    prescale = 6'd8;
    par_en   = 1'b0;
    rx       = 1'b0;
    repeat (2) @(negedge clk);
    idle(40);
    check("t2_glitch_dv", dv_n - b_dv, 0);
    check("t2_glitch_pe", pe_n - b_pe, 0);
    check("t2_glitch_se", se_n - b_se, 0);
    snap();
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(32);
    check("t2_dv_cnt", dv_n - b_dv, 1);
    check("t2_dv_lat", dv_cyc[b_dv % 16] - t0, 78 + ADJ);
    check("t2_data", dv_dat[b_dv % 16], 8'h3C);

    // P=16, odd parity, 0x3C with wrong parity bit 0
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(64);
    check("t3_pe_cnt", pe_n - b_pe, 1);
    check("t3_pe_lat", pe_cyc - t0, 170 + ADJ);
    check("t3_dv_cnt", dv_n - b_dv, 0);
    check("t3_se_cnt", se_n - b_se, 0);
    check("t3_pdata_hold", p_data, 8'h3C);

    // P=32, no parity, 0x81 with stop bit 0
    snap();
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(128);
    check("t4_se_cnt", se_n - b_se, 1);
    check("t4_se_lat", se_cyc - t0, 306 + ADJ);
    check("t4_dv_cnt", dv_n - b_dv, 0);
    check("t4_pe_cnt", pe_n - b_pe, 0);
    check("t4_pdata_hold", p_data, 8'h3C);

    // P=16 back-to-back 0x55, 0xFF
    snap();
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    t0a = t0;
    send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(64);
    check("t5_dv_cnt", dv_n - b_dv, 2);
    check("t5_lat0", dv_cyc[b_dv % 16] - t0a, 154 + ADJ);
    check("t5_data0", dv_dat[b_dv % 16], 8'h55);
    check("t5_gap", dv_cyc[(b_dv + 1) % 16] - dv_cyc[b_dv % 16], 160);
    check("t5_data1", dv_dat[(b_dv + 1) % 16], 8'hFF);
    check("t5_err_cnt", (pe_n - b_pe) + (se_n - b_se), 0);

    // reset during DATA, then 0x0F
    snap();
    prescale = 6'd8;
    par_en   = 1'b0;
    rx       = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    check("t6_rst_pdata", p_data, 8'h00);
    check("t6_rst_dv", data_valid, 1'b0);
    check("t6_rst_pe", par_err, 1'b0);
    check("t6_rst_se", stp_err, 1'b0);
    rst = 1'b1;
    idle(100);
    check("t6_drop_dv", dv_n - b_dv, 0);
    check("t6_drop_err", (pe_n - b_pe) + (se_n - b_se), 0);
    snap();
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(32);
    check("t6_dv_cnt", dv_n - b_dv, 1);
    check("t6_dv_lat", dv_cyc[b_dv % 16] - t0, 78 + ADJ);
    check("t6_data", dv_dat[b_dv % 16], 8'h0F);
    check("t6_pdata", p_data, 8'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
